seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Sequential signed divider; the inverse operation of the team's combinational 4x4 signed multiplier.
- Takes an 8-bit two's-complement dividend and a 4-bit two's-complement divisor.
- Returns a signed quotient and remainder, truncating toward zero, through a start/done handshake.
- Uses the same sign-magnitude approach as the multiplier: magnitudes in, unsigned restoring division, sign fixed at the end by XOR of the operand MSBs.

Parameters:
- WD, 8, dividend and quotient width.
- WV, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WD  signed dividend; captured on the accepted start edge.
- divisor  input  WV  signed divisor; captured on the accepted start edge.
- busy  output  1  high from the accept edge until done is asserted.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WD  signed quotient.
- remainder  output  WV  signed remainder; takes the dividend's sign (zero when the remainder is zero).
- dbz  output  1  divide-by-zero flag, valid with done.
- ovf  output  1  quotient overflow flag, valid with done.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, quotient, remainder, dbz, ovf all 0; internal registers cleared.
- States:
  - IDLE: start=1 at edge k -> capture magnitudes |dividend| (WD bits unsigned) and |divisor| (WV bits unsigned).
    - Capture sign bits neg_q = dividend[WD-1] ^ divisor[WV-1] and neg_r = dividend[WD-1].
    - Clear partial remainder (WV+1 bits) and count; busy=1.
    - Next state CALC, or ZERO if divisor==0.
  - CALC: one quotient bit per edge, restoring algorithm, MSB first.
    - Shift {partial remainder, dividend magnitude} left 1.
    - Trial subtract the divisor magnitude. If non-negative, keep the result and set the quotient bit to 1; otherwise restore and set it to 0.
    - count increments each edge; after WD iterations (edges k+1..k+8) go to SIGN.
  - SIGN (edge k+9):
    - quotient = neg_q ? -q_mag : q_mag; remainder = neg_r ? -r_mag : r_mag.
    - ovf=1 when !neg_q and q_mag[WD-1]==1 (only case -128/-1 -> 128); quotient then wraps to 8'h80.
    - dbz=0; done=1; busy=0; next state IDLE.
  - ZERO (edge k+1): quotient=0, remainder=0, dbz=1, ovf=0, done=1, busy=0; next state IDLE.
- Latency: done is high in the cycle after edge k+9 (normal) or edge k+1 (divide by zero).
  - A new start is accepted on the same edge done is visible, i.e. back-to-back operations every 10 cycles.
- done is high for exactly one cycle. quotient, remainder, dbz and ovf hold until the next SIGN/ZERO update or reset.
- start while busy is ignored (no queueing). Input changes after the accept edge do not affect the result.
- Magnitude of the most negative value: |-128| = 8'h80 unsigned, |-8| = 4'h8 unsigned; both handled without overflow internally.
- |remainder| < |divisor| <= 8, so remainder always fits WV signed bits.
- Reset mid-operation: immediate return to IDLE. No done pulse, outputs cleared; the aborted operation is lost.

Decomposition:
- Shared package (mult/div arithmetic), holding:
  - default widths WD=8, WV=4;
  - FSM state encodings IDLE/CALC/SIGN/ZERO as localparams (2-bit);
  - counter width constant clog2(WD+1).
- One natural sub-module: twos_mag (parameterised width).
  - Combinational: signed input -> unsigned magnitude plus sign bit.
  - Instantiated twice for operand capture; also reusable by the multiplier.
- FSM, datapath and sign fix stay in seq_signed_divider.

Test Plan:
- 100 / 7 -> done after 10 cycles; quotient=8'h0E (14), remainder=4'h2, dbz=0, ovf=0.
- -100 / 7 -> quotient=8'hF2 (-14), remainder=4'hE (-2). Then 100 / -7 -> quotient=8'hF2, remainder=4'h2. Then -100 / -7 -> quotient=8'h0E, remainder=4'hE.
- -128 / -1 -> quotient=8'h80, remainder=0, ovf=1. Also -128 / -8 -> quotient=8'h10 (16), remainder=0, ovf=0.
- 55 / 0 -> done 2 cycles after start; dbz=1, quotient=0, remainder=0; busy high for exactly 1 cycle.
- Start 100/7, pulse start with 9/3 while busy, change the operand inputs mid-op -> single done with quotient=14, remainder=2; the second start is ignored.
- Start 100/7, drop rst_n at cycle 4 for 1 cycle -> no done, all outputs 0. Restart 7/7 -> quotient=1, remainder=0.

Source files
------------

// File: rtl/seq_signed_divider_pkg.sv
// Shared arithmetic definitions for the signed multiplier/divider pair.
// Holds default widths, divider FSM encoding and counter sizing.
package seq_signed_divider_pkg;

    localparam int WD_DEF = 8;
    localparam int WV_DEF = 4;

    // Iteration counter sized to hold 0..WD
    localparam int CNT_W = $clog2(WD_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        ZERO = 2'd3
    } state_t;

endpackage

// File: rtl/seq_signed_divider_twos_mag.sv
// Two's-complement to sign-magnitude converter (combinational).
// Ports: value (signed in), mag (unsigned magnitude), sign (input MSB).
module seq_signed_divider_twos_mag #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] mag,
    output logic         sign
);

    // The most negative value maps to 2^(W-1), which fits W unsigned bits
    always_comb begin
        sign = value[W-1];
        mag  = sign ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, sign fixed at end.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done, quotient, remainder, dbz, ovf.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WD = WD_DEF,
    parameter int WV = WV_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WD-1:0] dividend,
    input  logic [WV-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WD-1:0] quotient,
    output logic [WV-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);

    localparam int CW = $clog2(WD + 1);

    state_t        state;
    logic [WD-1:0] dq;
    logic [WV-1:0] dv;
    logic [WV:0]   pr;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;

    logic [WD-1:0] a_mag;
    logic          a_sign;
    logic [WV-1:0] b_mag;
    logic          b_sign;

    logic [WV:0]   pr_sh;
    logic [WV+1:0] diff;
    logic [WD-1:0] q_fix;
    logic [WV-1:0] r_fix;

    seq_signed_divider_twos_mag #(.W(WD)) u_mag_a (
        .value (dividend),
        .mag   (a_mag),
        .sign  (a_sign)
    );

    seq_signed_divider_twos_mag #(.W(WV)) u_mag_b (
        .value (divisor),
        .mag   (b_mag),
        .sign  (b_sign)
    );

    // dq doubles as dividend shifter and quotient accumulator
    always_comb begin
        pr_sh = {pr[WV-1:0], dq[WD-1]};
        diff  = {1'b0, pr_sh} - {2'b00, dv};
        q_fix = neg_q ? (~dq + {{(WD-1){1'b0}}, 1'b1}) : dq;
        r_fix = neg_r ? (~pr[WV-1:0] + {{(WV-1){1'b0}}, 1'b1})
                      : pr[WV-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dq        <= '0;
            dv        <= '0;
            pr        <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dq    <= a_mag;
                        dv    <= b_mag;
                        neg_q <= a_sign ^ b_sign;
                        neg_r <= a_sign;
                        pr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (b_mag == '0) ? ZERO : CALC;
                    end
                end
                CALC: begin
                    if (!diff[WV+1]) begin
                        pr <= diff[WV:0];
                        dq <= {dq[WD-2:0], 1'b1};
                    end else begin
                        pr <= pr_sh;
                        dq <= {dq[WD-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WD - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    // Only -2^(WD-1) / -1 yields a positive magnitude with MSB set
                    ovf       <= !neg_q && dq[WD-1];
                    dbz       <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                ZERO: begin
                    quotient  <= '0;
                    remainder <= '0;
                    ovf       <= 1'b0;
                    dbz       <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: vector table + corner sequences.
// Expected results are queued at start and checked when done pulses.
module tb_seq_signed_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        exp_t       e;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    seq_signed_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("dbz", 32'(dbz), 32'(e.dbz));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                         input exp_t e, input int lat);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("busy_after_accept", 32'(busy), 32'(lat > 2 || !done));
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("quotient_hold", 32'(quotient), 32'(e.q));
    endtask

    initial begin
        int base;
        int n;
        vecs[0]  = '{8'd100, 4'd7, '{8'h0E, 4'h2, 1'b0, 1'b0}, 10};
        vecs[1]  = '{8'h9C,  4'd7, '{8'hF2, 4'hE, 1'b0, 1'b0}, 10};
        vecs[2]  = '{8'd100, 4'h9, '{8'hF2, 4'h2, 1'b0, 1'b0}, 10};
        vecs[3]  = '{8'h9C,  4'h9, '{8'h0E, 4'hE, 1'b0, 1'b0}, 10};
        vecs[4]  = '{8'h80,  4'hF, '{8'h80, 4'h0, 1'b0, 1'b1}, 10};
        vecs[5]  = '{8'h80,  4'h8, '{8'h10, 4'h0, 1'b0, 1'b0}, 10};
        vecs[6]  = '{8'd55,  4'h0, '{8'h00, 4'h0, 1'b1, 1'b0}, 2};
        vecs[7]  = '{8'h7F,  4'h1, '{8'h7F, 4'h0, 1'b0, 1'b0}, 10};
        vecs[8]  = '{8'hFF,  4'h8, '{8'h00, 4'hF, 1'b0, 1'b0}, 10};
        vecs[9]  = '{8'h00,  4'h5, '{8'h00, 4'h0, 1'b0, 1'b0}, 10};
        vecs[10] = '{8'hF9,  4'h2, '{8'hFD, 4'hF, 1'b0, 1'b0}, 10};
        vecs[11] = '{8'h7F,  4'h8, '{8'hF1, 4'h7, 1'b0, 1'b0}, 10};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat);
        end

        // Start while busy and operand changes must not disturb the result
        base = done_cnt;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        sb.push_back('{8'h0E, 4'h2, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd9;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'hC0;
        divisor  = 4'hD;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ignored_start_done_seen", 32'(done), 32'd1);
        repeat (14) @(negedge clk);
        chk("ignored_start_single_done", 32'(done_cnt - base), 32'd1);

        // Reset mid-operation aborts without a done pulse
        base = done_cnt;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_flags", 32'({done, dbz, ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        chk("abort_quotient_after", 32'(quotient), 32'd0);

        do_op(8'd7, 4'd7, '{8'h01, 4'h0, 1'b0, 1'b0}, 10);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
